// File: rtl/fetch_redirect_unit.sv
// ============================================================================
// fetch_redirect_unit
// ----------------------------------------------------------------------------
// Purpose:
//   Owns the fetch PC and follows the branch predictor's same-cycle decision.
//   Each fetched instruction's prediction rides through the F->D and D->E
//   pipeline registers. In execute it is compared with the real control-flow
//   outcome. On a mismatch the unit redirects fetch to the correct PC and
//   squashes the two younger stages. pc_e and valid_e are exported so the
//   predictor trains only on real instructions and never on bubbles.
//
// Parameters:
//   RESET_PC : fetch address loaded while start is low.
//   CNT_W    : width of the resolved-control-flow and mispredict counters.
//
// Ports:
//   clk              in   rising-edge system clock
//   start            in   asynchronous active-low reset (low = reset)
//   stall_f          in   hold pc_f
//   stall_d          in   hold the D record and inject a bubble into E
//   pc_f             out  current fetch PC (to predictor and I-memory)
//   pred_taken       in   predictor decision for pc_f, same cycle
//   pred_target      in   predicted target for pc_f, same cycle
//   cflow_mode       in   execute-stage control-flow class
//   cflow_taken      in   actual taken outcome in execute
//   cflow_target     in   actual target in execute
//   pc_e             out  PC of the instruction in execute
//   valid_e          out  execute slot holds a real instruction
//   mispredict       out  combinational; redirect this cycle
//   redirect_pc      out  correct next PC (meaningful when mispredict=1)
//   cflow_count      out  resolved control-flow instructions
//   mispredict_count out  mispredicts
// ============================================================================

package fetch_redirect_pkg;

    // Execute-stage control-flow class. Only BRANCH, JAL and JALR count as
    // control flow; every other encoding (NONE and the spare codes 4..7) is
    // treated as an ordinary instruction.
    typedef enum logic [2:0] {
        CFLOW_NONE   = 3'd0,
        CFLOW_BRANCH = 3'd1,
        CFLOW_JAL    = 3'd2,
        CFLOW_JALR   = 3'd3
    } cflow_mode_t;

endpackage : fetch_redirect_pkg

module fetch_redirect_unit
    import fetch_redirect_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic              clk,
    input  logic              start,
    input  logic              stall_f,
    input  logic              stall_d,
    output logic [31:0]       pc_f,
    input  logic              pred_taken,
    input  logic [31:0]       pred_target,
    input  cflow_mode_t       cflow_mode,
    input  logic              cflow_taken,
    input  logic [31:0]       cflow_target,
    output logic [31:0]       pc_e,
    output logic              valid_e,
    output logic              mispredict,
    output logic [31:0]       redirect_pc,
    output logic [CNT_W-1:0]  cflow_count,
    output logic [CNT_W-1:0]  mispredict_count
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [31:0]      r_pc_f;

    logic             r_valid_d;
    logic [31:0]      r_pc_d;
    logic             r_pred_taken_d;
    logic [31:0]      r_pred_target_d;

    logic             r_valid_e;
    logic [31:0]      r_pc_e;
    logic             r_pred_taken_e;
    logic [31:0]      r_pred_target_e;

    logic [CNT_W-1:0] r_cflow_count;
    logic [CNT_W-1:0] r_mispredict_count;

    // ------------------------------------------------------------------------
    // Execute-stage resolution
    // ------------------------------------------------------------------------
    logic             w_is_cf;
    logic             w_act_taken;
    logic [31:0]      w_pc_e_plus4;
    logic [31:0]      w_act_pc;
    logic             w_dir_wrong;
    logic             w_target_wrong;
    logic             w_mispredict;

    // The actual outcome is only meaningful for real control-flow classes;
    // a stray cflow_taken on an ordinary instruction is ignored. Predicting
    // taken on a non-control-flow instruction (a BTB alias) therefore shows
    // up as a direction error and redirects to pc_e+4.
    always_comb begin
        w_is_cf        = (cflow_mode == CFLOW_BRANCH) ||
                         (cflow_mode == CFLOW_JAL)    ||
                         (cflow_mode == CFLOW_JALR);
        w_act_taken    = w_is_cf & cflow_taken;
        w_pc_e_plus4   = r_pc_e + 32'd4;
        w_act_pc       = w_act_taken ? cflow_target : w_pc_e_plus4;
        w_dir_wrong    = (w_act_taken != r_pred_taken_e);
        w_target_wrong = w_act_taken & r_pred_taken_e &
                         (cflow_target != r_pred_target_e);
        w_mispredict   = r_valid_e & (w_dir_wrong | w_target_wrong);
    end

    // ------------------------------------------------------------------------
    // Fetch PC
    // ------------------------------------------------------------------------
    // A redirect beats a fetch stall: the instruction being held is on the
    // wrong path anyway. It also beats the predictor, whose decision refers
    // to a fetch that the squash throws away.
    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            r_pc_f <= RESET_PC;
        end else if (w_mispredict) begin
            r_pc_f <= w_act_pc;
        end else if (stall_f) begin
            r_pc_f <= r_pc_f;
        end else if (pred_taken) begin
            r_pc_f <= pred_target;
        end else begin
            r_pc_f <= r_pc_f + 32'd4;
        end
    end

    // ------------------------------------------------------------------------
    // F->D register
    // ------------------------------------------------------------------------
    // A squash only drops the valid bit. The payload is irrelevant until the
    // next real load.
    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            r_valid_d       <= 1'b0;
            r_pc_d          <= 32'h0;
            r_pred_taken_d  <= 1'b0;
            r_pred_target_d <= 32'h0;
        end else if (w_mispredict) begin
            r_valid_d       <= 1'b0;
        end else if (!stall_d) begin
            r_valid_d       <= 1'b1;
            r_pc_d          <= r_pc_f;
            r_pred_taken_d  <= pred_taken;
            r_pred_target_d <= pred_target;
        end
    end

    // ------------------------------------------------------------------------
    // D->E register
    // ------------------------------------------------------------------------
    // Both a squash and a decode stall leave E empty. The D record stays put
    // during the stall and moves on once the stall releases.
    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            r_valid_e       <= 1'b0;
            r_pc_e          <= 32'h0;
            r_pred_taken_e  <= 1'b0;
            r_pred_target_e <= 32'h0;
        end else if (w_mispredict || stall_d) begin
            r_valid_e       <= 1'b0;
        end else begin
            r_valid_e       <= r_valid_d;
            r_pc_e          <= r_pc_d;
            r_pred_taken_e  <= r_pred_taken_d;
            r_pred_target_e <= r_pred_target_d;
        end
    end

    // ------------------------------------------------------------------------
    // Statistics counters
    // ------------------------------------------------------------------------
    // Both counters wrap naturally. A mispredicted branch bumps both in the
    // same cycle.
    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            r_cflow_count      <= '0;
            r_mispredict_count <= '0;
        end else begin
            if (r_valid_e && w_is_cf) begin
                r_cflow_count <= r_cflow_count + CNT_W'(1);
            end
            if (w_mispredict) begin
                r_mispredict_count <= r_mispredict_count + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign pc_f             = r_pc_f;
    assign pc_e             = r_pc_e;
    assign valid_e          = r_valid_e;
    assign mispredict       = w_mispredict;
    assign redirect_pc      = w_act_pc;
    assign cflow_count      = r_cflow_count;
    assign mispredict_count = r_mispredict_count;

endmodule : fetch_redirect_unit

// File: tb/tb_fetch_redirect_unit.sv
// ============================================================================
// tb_fetch_redirect_unit
// ----------------------------------------------------------------------------
// Directed scenarios with literal expectations, followed by a long
// randomized run. A transaction-level model tracks the fetch PC, the
// instruction records in D and E, and both counters. The model is checked
// against the DUT at every falling edge.
// ============================================================================

module tb_fetch_redirect_unit;
    import fetch_redirect_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          CNT_W    = 32;

    logic              clk = 1'b0;
    logic              start;
    logic              stall_f;
    logic              stall_d;
    logic [31:0]       pc_f;
    logic              pred_taken;
    logic [31:0]       pred_target;
    cflow_mode_t       cflow_mode;
    logic              cflow_taken;
    logic [31:0]       cflow_target;
    logic [31:0]       pc_e;
    logic              valid_e;
    logic              mispredict;
    logic [31:0]       redirect_pc;
    logic [CNT_W-1:0]  cflow_count;
    logic [CNT_W-1:0]  mispredict_count;

    always #5 clk = ~clk;

    fetch_redirect_unit #(
        .RESET_PC (RESET_PC),
        .CNT_W    (CNT_W)
    ) dut (
        .clk              (clk),
        .start            (start),
        .stall_f          (stall_f),
        .stall_d          (stall_d),
        .pc_f             (pc_f),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .cflow_mode       (cflow_mode),
        .cflow_taken      (cflow_taken),
        .cflow_target     (cflow_target),
        .pc_e             (pc_e),
        .valid_e          (valid_e),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .cflow_count      (cflow_count),
        .mispredict_count (mispredict_count)
    );

    // ------------------------------------------------------------------------
    // Reference model: an instruction record per stage
    // ------------------------------------------------------------------------
    typedef struct {
        bit          v;
        logic [31:0] pc;
        bit          pt;
        logic [31:0] ptg;
    } rec_t;

    logic [31:0] mPcF;
    rec_t        mD;
    rec_t        mE;
    logic [31:0] mCfCnt;
    logic [31:0] mMpCnt;
    bit          mMispredict;
    logic [31:0] mRedirect;

    int nAsserts = 0;
    int nFails   = 0;

    function automatic bit isCf(cflow_mode_t m);
        return (m == CFLOW_BRANCH) || (m == CFLOW_JAL) || (m == CFLOW_JALR);
    endfunction

    function void modelReset();
        mPcF   = RESET_PC;
        mD     = '{1'b0, 32'h0, 1'b0, 32'h0};
        mE     = '{1'b0, 32'h0, 1'b0, 32'h0};
        mCfCnt = 32'h0;
        mMpCnt = 32'h0;
    endfunction

    // Resolve the instruction in E against the current execute inputs.
    function void evalModel();
        bit actTaken;
        actTaken    = isCf(cflow_mode) && cflow_taken;
        mRedirect   = actTaken ? cflow_target : mE.pc + 32'd4;
        mMispredict = mE.v && ((actTaken != mE.pt) ||
                               (actTaken && mE.pt && cflow_target != mE.ptg));
    endfunction

    // Advance the model by one clock using the inputs held during the cycle.
    function void modelStep();
        logic [31:0] np;
        rec_t        nd;
        rec_t        ne;
        evalModel();
        if (mMispredict)     np = mRedirect;
        else if (stall_f)    np = mPcF;
        else if (pred_taken) np = pred_target;
        else                 np = mPcF + 32'd4;
        nd = mD;
        if (mMispredict)     nd.v = 1'b0;
        else if (!stall_d)   nd = '{1'b1, mPcF, pred_taken, pred_target};
        ne = mD;
        if (mMispredict || stall_d) begin
            ne   = mE;
            ne.v = 1'b0;
        end
        if (mE.v && isCf(cflow_mode)) mCfCnt = mCfCnt + 32'd1;
        if (mMispredict)              mMpCnt = mMpCnt + 32'd1;
        mPcF = np;
        mD   = nd;
        mE   = ne;
    endfunction

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    function void checkLit(string name, logic [31:0] act, logic [31:0] exp);
        nAsserts++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function void checkOutput();
        evalModel();
        checkLit("pc_f", pc_f, mPcF);
        checkLit("valid_e", 32'(valid_e), 32'(mE.v));
        if (mE.v) checkLit("pc_e", pc_e, mE.pc);
        checkLit("mispredict", 32'(mispredict), 32'(mMispredict));
        if (mMispredict) checkLit("redirect_pc", redirect_pc, mRedirect);
        checkLit("cflow_count", cflow_count, mCfCnt);
        checkLit("mispredict_count", mispredict_count, mMpCnt);
    endfunction

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic applyStimulus(input bit sf, input bit sd, input bit pt,
                                 input logic [31:0] ptg, input cflow_mode_t m,
                                 input bit tk, input logic [31:0] tg);
        stall_f      = sf;
        stall_d      = sd;
        pred_taken   = pt;
        pred_target  = ptg;
        cflow_mode   = m;
        cflow_taken  = tk;
        cflow_target = tg;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, CFLOW_NONE, 1'b0, 32'h0);
    endtask

    task automatic sample();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        modelStep();
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    // Reset is pulled mid-cycle and checked at once. It is released just
    // after the following rising edge.
    task automatic doReset();
        #2;
        start = 1'b0;
        #1;
        checkLit("rst_async_pc_f", pc_f, RESET_PC);
        checkLit("rst_async_valid_e", 32'(valid_e), 32'h0);
        checkLit("rst_async_mispredict", 32'(mispredict), 32'h0);
        checkLit("rst_async_cflow_count", cflow_count, 32'h0);
        checkLit("rst_async_mp_count", mispredict_count, 32'h0);
        modelReset();
        @(posedge clk);
        #1;
        start = 1'b1;
    endtask

    task automatic idleUntilF(input logic [31:0] pc);
        bit found = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (mPcF == pc) begin
                found = 1'b1;
                break;
            end
            applyIdle();
            cycle();
        end
        checkLit("reach_pc_f", 32'(found), 32'h1);
    endtask

    task automatic idleUntilE(input logic [31:0] pc);
        bit found = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (mE.v && mE.pc == pc) begin
                found = 1'b1;
                break;
            end
            applyIdle();
            cycle();
        end
        checkLit("reach_pc_e", 32'(found), 32'h1);
    endtask

    function automatic logic [31:0] randTarget();
        int r = $urandom_range(0, 9);
        if (r < 7)       return {22'h0, 8'($urandom_range(0, 255)), 2'b00};
        else if (r == 7) return 32'hFFFF_FFFC;
        else             return $urandom;
    endfunction

    task automatic randomStimulus();
        bit          sf  = ($urandom_range(0, 4) == 0);
        bit          sd  = ($urandom_range(0, 4) == 0);
        bit          pt  = ($urandom_range(0, 2) == 0);
        logic [31:0] ptg = randTarget();
        cflow_mode_t m;
        bit          tk;
        logic [31:0] tg;
        if ($urandom_range(0, 1) == 0 && mE.v) begin
            if (mE.pt) begin
                m  = cflow_mode_t'(3'($urandom_range(1, 3)));
                tk = 1'b1;
                tg = mE.ptg;
            end else begin
                m  = ($urandom_range(0, 1) == 0) ? CFLOW_NONE : CFLOW_BRANCH;
                tk = 1'b0;
                tg = randTarget();
            end
        end else begin
            m  = cflow_mode_t'(3'($urandom_range(0, 7)));
            tk = 1'($urandom_range(0, 1));
            tg = ($urandom_range(0, 1) == 0) ? mE.ptg : randTarget();
        end
        applyStimulus(sf, sd, pt, ptg, m, tk, tg);
    endtask

    // ------------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------------
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        start = 1'b0;
        applyIdle();
        modelReset();
        @(posedge clk);
        #1;
        checkLit("rst_pc_f", pc_f, RESET_PC);
        checkLit("rst_valid_e", 32'(valid_e), 32'h0);
        checkLit("rst_mispredict", 32'(mispredict), 32'h0);
        checkLit("rst_cflow_count", cflow_count, 32'h0);
        checkLit("rst_mp_count", mispredict_count, 32'h0);
        start = 1'b1;

        // Sequential fetch; E fills two cycles after release.
        for (int k = 0; k < 4; k++) begin
            applyIdle();
            sample();
            checkLit("seq_pc_f", pc_f, 32'(4 * k));
            if (k < 2) checkLit("seq_valid_e_low", 32'(valid_e), 32'h0);
            if (k == 2) begin
                checkLit("seq_first_valid_e", 32'(valid_e), 32'h1);
                checkLit("seq_first_pc_e", pc_e, 32'h0);
            end
            advance();
        end

        // Correct taken prediction at 0x10 -> 0x80.
        idleUntilF(32'h10);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h80, CFLOW_NONE, 1'b0, 32'h0);
        cycle();
        checkLit("pred_pc_f", pc_f, 32'h80);
        idleUntilE(32'h10);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, CFLOW_BRANCH, 1'b1, 32'h80);
        sample();
        checkLit("bt_ok_mispredict", 32'(mispredict), 32'h0);
        checkLit("bt_ok_pc_e", pc_e, 32'h10);
        advance();
        checkLit("bt_ok_cflow_count", cflow_count, 32'h1);

        // Branch at 0x20 predicted not taken, actually taken to 0x200.
        doReset();
        idleUntilE(32'h20);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, CFLOW_BRANCH, 1'b1, 32'h200);
        sample();
        checkLit("dir_mispredict", 32'(mispredict), 32'h1);
        checkLit("dir_redirect_pc", redirect_pc, 32'h200);
        advance();
        checkLit("dir_pc_f", pc_f, 32'h200);
        checkLit("dir_valid_e", 32'(valid_e), 32'h0);
        checkLit("dir_mp_count", mispredict_count, 32'h1);
        applyIdle();
        cycle();
        checkLit("dir_bubble_e", 32'(valid_e), 32'h0);
        applyIdle();
        cycle();
        checkLit("dir_first_valid_e", 32'(valid_e), 32'h1);
        checkLit("dir_first_pc_e", pc_e, 32'h200);

        // JALR at 0x40 predicted to 0x100, actually to 0x140.
        doReset();
        idleUntilF(32'h40);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h100, CFLOW_NONE, 1'b0, 32'h0);
        cycle();
        idleUntilE(32'h40);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, CFLOW_JALR, 1'b1, 32'h140);
        sample();
        checkLit("tgt_mispredict", 32'(mispredict), 32'h1);
        checkLit("tgt_redirect_pc", redirect_pc, 32'h140);
        advance();

        // Non-control-flow at 0x60 carrying a taken prediction (BTB alias).
        doReset();
        idleUntilF(32'h60);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h300, CFLOW_NONE, 1'b0, 32'h0);
        cycle();
        idleUntilE(32'h60);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, cflow_mode_t'(3'd5), 1'b1, 32'h999);
        sample();
        checkLit("alias_mispredict", 32'(mispredict), 32'h1);
        checkLit("alias_redirect_pc", redirect_pc, 32'h64);
        advance();
        checkLit("alias_cflow_count", cflow_count, 32'h0);
        checkLit("alias_mp_count", mispredict_count, 32'h1);

        // Two stall cycles, then a mispredict that arrives during a stall.
        doReset();
        idleUntilF(32'h10);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, CFLOW_NONE, 1'b0, 32'h0);
            cycle();
            checkLit("stall_pc_f", pc_f, 32'h10);
            checkLit("stall_valid_e", 32'(valid_e), 32'h0);
        end
        applyIdle();
        cycle();
        checkLit("stall_release_valid_e", 32'(valid_e), 32'h1);
        checkLit("stall_release_pc_e", pc_e, 32'hC);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, CFLOW_BRANCH, 1'b1, 32'h400);
        sample();
        checkLit("stall_mp_mispredict", 32'(mispredict), 32'h1);
        advance();
        checkLit("stall_mp_pc_f", pc_f, 32'h400);
        checkLit("stall_mp_valid_e", 32'(valid_e), 32'h0);
        applyIdle();
        cycle();
        checkLit("stall_mp_d_cleared", 32'(valid_e), 32'h0);

        // Redirect to the top of the address space; fetch wraps to 0.
        doReset();
        idleUntilE(32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, CFLOW_JAL, 1'b1, 32'hFFFF_FFFC);
        cycle();
        checkLit("wrap_pc_f", pc_f, 32'hFFFF_FFFC);
        applyIdle();
        cycle();
        checkLit("wrap_pc_f_next", pc_f, 32'h0);

        // Reset pulled while a redirect is pending.
        idleUntilE(32'h4);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, CFLOW_BRANCH, 1'b1, 32'h500);
        doReset();
        checkLit("rst_mid_pc_f", pc_f, RESET_PC);
        applyIdle();
        cycle();
        checkLit("rst_mid_pc_f_next", pc_f, RESET_PC + 32'd4);

        // Randomized run with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) doReset();
            randomStimulus();
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule : tb_fetch_redirect_unit

// File: doc/fetch_redirect_unit.md
Name: fetch_redirect_unit

Overview:
- Owns the fetch PC register and consumes the predictor's same-cycle outputs (pred_taken, pred_target) to choose the next fetch PC.
- Carries each fetched instruction's prediction through its F->D and D->E pipeline registers.
- Resolves the prediction in execute against the actual control-flow outcome, and on a mismatch redirects fetch and squashes younger stages.
- Exports pc_e and a valid qualifier so the predictor trains only on real instructions, never on bubbles.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset.
- CNT_W, 32, width of the resolved-control-flow and mispredict counters.

Ports:
- clk  in  1  system clock, rising edge.
- start  in  1  asynchronous active-low reset; low = reset.
- stall_f  in  1  hazard unit: hold pc_f.
- stall_d  in  1  hazard unit: hold the D register and inject a bubble into E.
- pc_f  out  32  current fetch PC, fed to the predictor and I-memory.
- pred_taken  in  1  predictor decision for pc_f, same cycle.
- pred_target  in  32  predicted target for pc_f, same cycle.
- cflow_mode  in  cflow_mode_t  execute-stage control-flow class (CFLOW_BRANCH/CFLOW_JAL/CFLOW_JALR; any other value = non-control-flow).
- cflow_taken  in  1  actual taken outcome in execute.
- cflow_target  in  32  actual target in execute.
- pc_e  out  32  PC of the instruction in execute.
- valid_e  out  1  execute slot holds a real instruction.
- mispredict  out  1  combinational; redirect this cycle.
- redirect_pc  out  32  correct next PC when mispredict=1.
- cflow_count  out  CNT_W  resolved control-flow instructions.
- mispredict_count  out  CNT_W  mispredicts.

Behaviour:
- Reset (start=0, asynchronous):
  - pc_f=RESET_PC.
  - D and E valid=0; D/E pc, pred_taken and pred_target = 0.
  - Both counters = 0.
  - Hence mispredict=0 and valid_e=0 during and immediately after reset.
- Actual outcome in E:
  - is_cf = cflow_mode is BRANCH, JAL or JALR.
  - act_taken = is_cf & cflow_taken.
  - act_pc = act_taken ? cflow_target : pc_e+4 (32-bit, wraps modulo 2^32).
- mispredict = valid_e & ( (act_taken != pred_taken_e) | (act_taken & pred_taken_e & cflow_target != pred_target_e) ).
  - A non-control-flow instruction predicted taken (BTB alias) is a mispredict with redirect_pc = pc_e+4.
- redirect_pc = act_pc. It is don't-care when mispredict=0 and is driven as act_pc anyway.
- Next pc_f, in priority order:
  1. mispredict -> redirect_pc.
  2. stall_f -> hold.
  3. pred_taken -> pred_target.
  4. Otherwise pc_f+4.
- F->D register:
  - mispredict -> valid_d=0 (squash).
  - else stall_d -> hold.
  - else load {1, pc_f, pred_taken, pred_target}.
- D->E register:
  - mispredict -> valid_e=0.
  - else stall_d -> valid_e=0 (bubble).
  - else load the D record.
- Mispredict has priority over both stalls in every register. Latency from the mispredict cycle: pc_f = redirect_pc at the next edge; D and E are empty for one cycle; the first correct-path instruction reaches E two cycles after it is fetched.
- Counters, on each clock:
  - cflow_count increments when valid_e & is_cf.
  - mispredict_count increments when mispredict.
  - Both wrap at 2^CNT_W.
  - A single cycle may increment both counters.
- Simultaneous mispredict and pred_taken: the redirect wins, and the fetched instruction is discarded by the squash.
- Reset asserted mid-redirect returns every state to its reset values; no redirect survives the reset.
- pc_f is not checked for alignment; low bits pass through unchanged.

Test Plan:
- Reset release, no stalls, pred_taken=0, non-cflow stream -> pc_f = 0,4,8,...; valid_e first rises 2 cycles after start rises; pc_e=0 in that cycle; counters stay 0.
- At pc_f=0x10 drive pred_taken=1, pred_target=0x80 -> next pc_f=0x80. Two cycles later E holds pc_e=0x10 with CFLOW_BRANCH, taken, target 0x80 -> mispredict=0; cflow_count=1.
- Branch at 0x20 predicted not-taken, resolves taken to 0x200 -> mispredict=1 in that cycle, redirect_pc=0x200; next cycle pc_f=0x200, valid_d=0, valid_e=0; mispredict_count=1.
- JALR at 0x40 predicted taken to 0x100, actual target 0x140 -> mispredict=1, redirect_pc=0x140.
- Non-cflow at 0x60 carrying pred_taken=1 -> mispredict=1, redirect_pc=0x64; cflow_count unchanged.
- stall_f=stall_d=1 for 2 cycles -> pc_f and the D record hold, valid_e=0 for both cycles. A mispredict asserted during that stall still redirects pc_f and clears D. Pulling start low at any point -> pc_f=RESET_PC and everything else cleared immediately.
